nmr_voter: RTL
==============

Name: nmr_voter

Overview:
- Registered N-modular-redundancy word voter: votes W-bit words from N redundant channels bit by bit.
- Tracks per-channel disagreement and permanently masks a channel after FAULT_THRESH consecutive mismatches.
- Sits between replicated datapath copies and the downstream consumer; the next generation of the fixed 3-input single-bit majority function.

Parameters:
N, 3, number of redundant channels; legal range 3..7.
W, 8, data width per channel.
FAULT_THRESH, 3, consecutive mismatching valid samples that mark a channel failed; legal range 1..15.
CNT_W, 8, width of per-channel cumulative error counters.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  all N channel words valid this cycle.
in_data  input  N*W  channel k occupies bits [k*W +: W].
clr_fault  input  1  one-cycle pulse; re-enables all channels and clears consecutive-mismatch counters.
out_valid  output  1  out_data valid.
out_data  output  W  voted word.
tie  output  1  at least one bit had no strict majority; that bit held its previous value.
mismatch  output  N  channel k disagreed with the voted word on the last valid sample.
failed  output  N  channel k is masked out of the vote.
all_failed  output  1  no active channels remain.
err_cnt  output  N*CNT_W  cumulative mismatch count per channel (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, tie=0, mismatch=0, failed=0, all_failed=0, err_cnt=0, internal consecutive counters=0.
- Latency is 1 cycle. out_valid is in_valid registered. All other outputs update only on edges where in_valid=1, except failed, all_failed and clr_fault effects.
- Active set: A = number of channels with failed[k]=0.
- Per-bit vote: ones = count of active channels with bit=1.
  - 2*ones > A gives 1.
  - 2*ones < A gives 0.
  - 2*ones == A (tie, including A=0) holds the previous out_data bit and sets tie=1 for that sample.
- Mismatch: mismatch[k] = active[k] AND (channel word != combinationally voted word). A failed channel always reports mismatch[k]=0.
- Per-channel state machine, advances on valid samples:
  - HEALTHY: cnt=0. A mismatch moves to SUSPECT with cnt=1.
  - SUSPECT: a match returns to HEALTHY with cnt=0. A mismatch increments cnt; when cnt reaches FAULT_THRESH, go to FAILED.
  - FAILED: failed[k]=1. Leaves only via clr_fault or rst.
  - With FAULT_THRESH=1, the first mismatch goes directly HEALTHY to FAILED.
- The vote on a sample uses the failed mask as it was before that edge. A channel that fails on edge t is excluded from edge t+1 onward.
- all_failed = (A==0) registered. While it is 1, out_data holds and tie=1 on every valid sample.
- clr_fault: on that edge every channel returns to HEALTHY with cnt=0 and failed=0; clear overrides any same-edge fault update. The sample present on that edge is still voted and flagged with the pre-clear mask. err_cnt is not cleared.
- Multiple channels may fail on the same edge; each is evaluated independently.
- Asynchronous reset mid-stream clears everything immediately. The first post-reset valid sample votes with all channels active.

Optional Feature:
- Macro: NMR_VOTER_ERRCNT_EN.
- Defined: err_cnt[k] increments by 1 on each valid sample with mismatch[k]=1, saturating at 2^CNT_W-1. It never wraps and is cleared only by rst.
- Undefined: no counter logic; err_cnt is driven constant 0.

Test Plan:
1. N=3, W=8, in_data={8'hA5,8'hA5,8'hA5}, in_valid=1 -> next cycle out_valid=1, out_data=8'hA5, tie=0, mismatch=3'b000.
2. Channel 1 = 8'h5A, others 8'hA5, for 2 consecutive valid samples, then all three 8'hA5 -> out_data=8'hA5 throughout, mismatch=3'b010 twice then 3'b000, failed stays 0.
3. Channel 2 = 8'hFF, others 8'h00, for 3 consecutive valid samples -> failed=3'b100 after the third edge. Then channels 0/1 = 8'h0F/8'hF0 -> tie=1 with out_data held at 8'h00.
4. After step 3, pulse clr_fault together with a valid sample of all 8'h11 -> failed=0 next cycle; the following sample votes with 3 active channels.
5. With NMR_VOTER_ERRCNT_EN defined and CNT_W=2, channel 0 mismatches 5 times -> err_cnt[0] reads 1,2,3,3,3 (saturating). With the macro undefined, err_cnt stays 0.
6. Assert rst mid-stream with failed=3'b011 and out_data=8'h3C -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nmr_voter.sv
// rtl/nmr_voter.sv - registered N-modular-redundancy word voter with per-channel fault masking
// Optional cumulative error counters: define NMR_VOTER_ERRCNT_EN.
module nmr_voter #(
  parameter int N            = 3,
  parameter int W            = 8,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [N*W-1:0]     in_data,
  input  logic               clr_fault,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic               tie,
  output logic [N-1:0]       mismatch,
  output logic [N-1:0]       failed,
  output logic               all_failed,
  output logic [N*CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {ST_HEALTHY, ST_SUSPECT, ST_FAILED} state_t;

  state_t         r_state     [N];
  state_t         w_state_nxt [N];
  logic [3:0]     r_cnt       [N];
  logic [3:0]     w_cnt_nxt   [N];
  logic [N-1:0]   w_active;
  logic [N-1:0]   w_failed_nxt;
  logic [N-1:0]   w_mismatch;
  logic [3:0]     w_num_active;
  logic [3:0]     w_ones;
  logic [W-1:0]   w_vote;
  logic           w_tie;

  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_tie;
  logic [N-1:0]   r_mismatch;
  logic           r_all_failed;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_active[k] = (r_state[k] != ST_FAILED);
    end
  end

  // Bitwise vote over the active set; an exact tie (including no voters) keeps the old bit.
  always_comb begin
    w_num_active = '0;
    w_ones       = '0;
    w_vote       = '0;
    w_tie        = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_num_active = w_num_active + 4'(w_active[k]);
    end
    for (int b = 0; b < W; b++) begin
      w_ones = '0;
      for (int k = 0; k < N; k++) begin
        w_ones = w_ones + 4'(w_active[k] & in_data[k*W + b]);
      end
      if ({w_ones, 1'b0} > {1'b0, w_num_active}) begin
        w_vote[b] = 1'b1;
      end else if ({w_ones, 1'b0} < {1'b0, w_num_active}) begin
        w_vote[b] = 1'b0;
      end else begin
        w_vote[b] = r_out_data[b];
        w_tie     = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      w_mismatch[k] = w_active[k] && (in_data[k*W +: W] != w_vote);
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      if (clr_fault) begin
        w_state_nxt[k] = ST_HEALTHY;
        w_cnt_nxt[k]   = '0;
      end else if (in_valid) begin
        case (r_state[k])
          ST_HEALTHY: begin
            if (w_mismatch[k]) begin
              w_cnt_nxt[k]   = 4'd1;
              w_state_nxt[k] = (FAULT_THRESH == 1) ? ST_FAILED : ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (w_mismatch[k]) begin
              w_cnt_nxt[k] = r_cnt[k] + 4'd1;
              if (r_cnt[k] + 4'd1 == 4'(FAULT_THRESH)) begin
                w_state_nxt[k] = ST_FAILED;
              end
            end else begin
              w_cnt_nxt[k]   = '0;
              w_state_nxt[k] = ST_HEALTHY;
            end
          end
          default: begin
            w_state_nxt[k] = r_state[k];
          end
        endcase
      end
      w_failed_nxt[k] = (w_state_nxt[k] == ST_FAILED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_state[k] <= ST_HEALTHY;
        r_cnt[k]   <= '0;
      end
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_tie        <= 1'b0;
      r_mismatch   <= '0;
      r_all_failed <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
      end
      r_out_valid  <= in_valid;
      r_all_failed <= &w_failed_nxt;
      if (in_valid) begin
        r_out_data <= w_vote;
        r_tie      <= w_tie;
        r_mismatch <= w_mismatch;
      end
    end
  end

`ifdef NMR_VOTER_ERRCNT_EN
  logic [CNT_W-1:0] r_err [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_err[k] <= '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) begin
        if (w_mismatch[k] && (r_err[k] != {CNT_W{1'b1}})) begin
          r_err[k] <= r_err[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      err_cnt[k*CNT_W +: CNT_W] = r_err[k];
    end
  end
`else
  assign err_cnt = '0;
`endif

  always_comb begin
    for (int k = 0; k < N; k++) begin
      failed[k] = (r_state[k] == ST_FAILED);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign tie        = r_tie;
  assign mismatch   = r_mismatch;
  assign all_failed = r_all_failed;

endmodule
